out_collector: RTL and testbench

//  Receiving end of the systolic array's stream-out path. Column c emits ROWS results one

---
 rtl/out_collector_pkg.sv | 14 +
 rtl/out_collector_skew_delay.sv | 36 +++
 rtl/out_collector.sv | 126 ++++++++++++
 tb/tb_out_collector.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_collector_pkg.sv
// Shared sizing defaults for the systolic-array stream-out path, plus a width helper
// that stays legal when a dimension collapses to one.
package out_collector_pkg;

   localparam int OC_OUT_WIDTH = 16;
   localparam int OC_ROWS      = 4;
   localparam int OC_COLS      = 4;
   localparam int OC_DEPTH     = 8;

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/out_collector_skew_delay.sv
// N-stage shift register used to re-align one array column; N=0 degenerates to a wire
// so the last column can share the same instantiation pattern.
module out_collector_skew_delay #(
   parameter int W = 17,
   parameter int N = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   if (N == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
   end else begin : g_pipe
      logic [W-1:0] stage [N];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < N; i++) begin
               stage[i] <= '0;
            end
         end else begin
            stage[0] <= din;
            for (int i = 1; i < N; i++) begin
               stage[i] <= stage[i-1];
            end
         end
      end

      assign dout = stage[N-1];
   end

endmodule

// File: rtl/out_collector.sv
// Stream-out collector: deskews the staggered column outputs of the array into whole rows,
// buffers them in a small row FIFO and hands them to writeback over valid/ready.
module out_collector
   import out_collector_pkg::*;
#(
   parameter int OUT_WIDTH = OC_OUT_WIDTH,
   parameter int ROWS      = OC_ROWS,
   parameter int COLS      = OC_COLS,
   parameter int DEPTH     = OC_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [COLS-1:0]           col_valid,
   input  logic [COLS*OUT_WIDTH-1:0] col_data,
   output logic                      tile_room,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COLS*OUT_WIDTH-1:0] out_data,
   output logic [bits_for(ROWS)-1:0] out_row,
   output logic                      out_last,
   output logic                      err_overflow,
   output logic                      err_skew
);

   localparam int DW = COLS * OUT_WIDTH;
   localparam int RW = bits_for(ROWS);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] ROWS_C   = CW'(ROWS);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   logic [COLS-1:0] dly_valid;
   logic [DW-1:0]   dly_data;

   // Earlier columns fire first, so column c waits COLS-1-c cycles for the last one.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [OUT_WIDTH:0] tap;

      out_collector_skew_delay #(
         .W(OUT_WIDTH + 1),
         .N(COLS - 1 - c)
      ) u_delay (
         .clk (clk),
         .rst (rst),
         .din ({col_valid[c], col_data[c*OUT_WIDTH +: OUT_WIDTH]}),
         .dout(tap)
      );

      assign dly_valid[c]                        = tap[OUT_WIDTH];
      assign dly_data[c*OUT_WIDTH +: OUT_WIDTH]  = tap[OUT_WIDTH-1:0];
   end

   logic          row_valid;
   logic          row_skew;
   logic          full;
   logic          push;
   logic          pop;
   logic          overflow;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [RW-1:0] wr_row;
   logic [DW-1:0] mem_data [DEPTH];
   logic [RW-1:0] mem_row  [DEPTH];

   // A partially valid aligned row means the producer skew is broken; it is never stored.
   assign row_valid = &dly_valid;
   assign row_skew  = (|dly_valid) && !row_valid;
   assign full      = (count == DEPTH_C);
   assign pop       = out_valid && out_ready;
   assign push      = row_valid && (!full || pop);
   assign overflow  = row_valid && full && !pop;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         wr_row       <= '0;
         tile_room    <= 1'b1;
         err_overflow <= 1'b0;
         err_skew     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + RW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count     <= count_next;
         tile_room <= (DEPTH_C - count_next) >= ROWS_C;
         if (overflow) begin
            err_overflow <= 1'b1;
         end
         if (row_skew) begin
            err_skew <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data[wr_ptr] <= dly_data;
         mem_row[wr_ptr]  <= wr_row;
      end
   end

   // Head is read straight from storage; an empty FIFO presents zeros rather than stale rows.
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_row   = out_valid ? mem_row[rd_ptr] : '0;
   assign out_last  = out_valid && (mem_row[rd_ptr] == LAST_ROW);

endmodule

// File: tb/tb_out_collector.sv
// Bench for out_collector: tiles are driven with the array's column skew, expected rows go
// into a scoreboard queue, and a negedge monitor checks every accepted row and every stall.
module tb_out_collector;

   localparam int OW    = 16;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int DEPTH = 8;
   localparam int DW    = COLS * OW;

   logic            clk = 1'b0;
   logic            rst;
   logic [COLS-1:0] col_valid;
   logic [DW-1:0]   col_data;
   logic            tile_room;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_row;
   logic            out_last;
   logic            err_overflow;
   logic            err_skew;

   always #5 clk = ~clk;

   out_collector #(
      .OUT_WIDTH(OW),
      .ROWS     (ROWS),
      .COLS     (COLS),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_valid   (col_valid),
      .col_data    (col_data),
      .tile_room   (tile_room),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_last    (out_last),
      .err_overflow(err_overflow),
      .err_skew    (err_skew)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    row;
   } exp_t;

   typedef struct {
      logic [15:0] base;
      int          mode;
      int          exp_rows;
      int          exp_lasts;
   } vec_t;

   exp_t       sb[$];
   vec_t       vecs[4];
   int         checks     = 0;
   int         passes     = 0;
   int         rows_seen  = 0;
   int         lasts_seen = 0;
   int         ready_mode = 0;
   logic [1:0] exp_wr_row = 2'd0;
   bit         abort_tile = 1'b0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   // 0 = never ready, 1 = always ready, 2 = toggle every cycle, 3 = random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      exp_t          e;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data  = '0;
      logic [1:0]    prev_row   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check_output("stall_valid", out_valid, 1);
               check_output("stall_data", out_data, prev_data);
               check_output("stall_row", out_row, prev_row);
            end
            if (out_valid && out_ready) begin
               rows_seen++;
               if (out_last) lasts_seen++;
               if (sb.size() == 0) begin
                  checks++;
                  $display("[TB] FAIL unexpected_row: got %0h, expected no row", out_data);
               end else begin
                  e = sb.pop_front();
                  check_output("row_data", out_data, e.data);
                  check_output("row_idx", out_row, e.row);
                  check_output("row_last", out_last, e.row == 2'd3);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_row   = out_row;
         end
      end
   end

   // Column c carries base+16c+r for row r at skew c; late_col adds one extra cycle to a column.
   task automatic apply_stimulus(input logic [15:0] base, input int late_col, input bit expect_rows);
      for (int s = 0; s <= ROWS; s++) begin
         int            nvalid = 0;
         logic [DW-1:0] d      = '0;
         exp_t          e;
         for (int c = 0; c < COLS; c++) begin
            int r = s - ((c == late_col) ? 1 : 0);
            if (r >= 0 && r < ROWS) begin
               nvalid++;
               d[c*OW +: OW] = base + 16'(16 * c + r);
            end
         end
         if (nvalid == COLS && expect_rows) begin
            e.data = d;
            e.row  = exp_wr_row;
            sb.push_back(e);
            exp_wr_row++;
         end
      end
      for (int k = 0; k < ROWS + COLS; k++) begin
         @(posedge clk);
         #1;
         if (abort_tile) break;
         for (int c = 0; c < COLS; c++) begin
            int r = k - c - ((c == late_col) ? 1 : 0);
            if (r >= 0 && r < ROWS) begin
               col_valid[c]        = 1'b1;
               col_data[c*OW +: OW] = base + 16'(16 * c + r);
            end else begin
               col_valid[c]        = 1'b0;
               col_data[c*OW +: OW] = '0;
            end
         end
      end
      col_valid = '0;
      col_data  = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check_output("drain_left", sb.size(), 0);
      check_output("drain_valid", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r0;
      int l0;
      vecs[0] = '{base: 16'h0100, mode: 1, exp_rows: 4, exp_lasts: 1};
      vecs[1] = '{base: 16'h0FF0, mode: 2, exp_rows: 4, exp_lasts: 1};
      vecs[2] = '{base: 16'hFFF8, mode: 3, exp_rows: 4, exp_lasts: 1};
      vecs[3] = '{base: 16'h8000, mode: 2, exp_rows: 4, exp_lasts: 1};

      rst       = 1'b1;
      col_valid = '0;
      col_data  = '0;
      @(posedge clk);
      @(negedge clk);
      check_output("rst_valid", out_valid, 0);
      check_output("rst_room", tile_room, 1);
      check_output("rst_data", out_data, 0);
      check_output("rst_row", out_row, 0);
      check_output("rst_last", out_last, 0);
      check_output("rst_ovf", err_overflow, 0);
      check_output("rst_skew", err_skew, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] single tile, latency");
      ready_mode = 1;
      fork
         apply_stimulus(16'h0000, -1, 1'b1);
         begin
            int n = 0;
            @(posedge clk);
            @(negedge clk);
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            check_output("first_valid_latency", n, 4);
         end
      join
      wait_drain(40);

      $display("[TB] table tiles");
      for (int i = 0; i < 4; i++) begin
         ready_mode = vecs[i].mode;
         r0 = rows_seen;
         l0 = lasts_seen;
         apply_stimulus(vecs[i].base, -1, 1'b1);
         wait_drain(80);
         check_output("vec_rows", rows_seen - r0, vecs[i].exp_rows);
         check_output("vec_lasts", lasts_seen - l0, vecs[i].exp_lasts);
      end

      $display("[TB] two tiles buffered, then overflow");
      ready_mode = 0;
      @(posedge clk);
      apply_stimulus(16'h1000, -1, 1'b1);
      check_output("room_after_4", tile_room, 1);
      fork
         apply_stimulus(16'h2000, -1, 1'b1);
         begin
            @(posedge clk);
            @(negedge clk);
            repeat (3) @(negedge clk);
            check_output("room_before_5th", tile_room, 1);
            @(negedge clk);
            check_output("room_after_5th", tile_room, 0);
         end
      join
      repeat (3) @(negedge clk);
      check_output("full_valid", out_valid, 1);
      check_output("full_ovf", err_overflow, 0);
      check_output("full_skew", err_skew, 0);
      apply_stimulus(16'h3000, -1, 1'b0);
      repeat (2) @(negedge clk);
      check_output("ovf_set", err_overflow, 1);
      check_output("ovf_room", tile_room, 0);
      r0 = rows_seen;
      ready_mode = 1;
      wait_drain(60);
      check_output("ovf_rows", rows_seen - r0, 8);

      $display("[TB] skewed column 2");
      r0 = rows_seen;
      apply_stimulus(16'h4000, 2, 1'b1);
      wait_drain(40);
      check_output("skew_set", err_skew, 1);
      check_output("skew_rows", rows_seen - r0, 3);
      check_output("skew_ovf_sticky", err_overflow, 1);

      $display("[TB] reset mid-tile");
      r0 = rows_seen;
      fork
         apply_stimulus(16'h5000, -1, 1'b1);
         begin
            int n = 0;
            while (rows_seen < r0 + 2 && n < 40) begin
               @(negedge clk);
               #1;
               n++;
            end
            if (n >= 40) timeout_fail("reset_wait");
            abort_tile = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b1;
            sb.delete();
            exp_wr_row = 2'd0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check_output("post_rst_valid", out_valid, 0);
            check_output("post_rst_room", tile_room, 1);
            check_output("post_rst_ovf", err_overflow, 0);
            check_output("post_rst_skew", err_skew, 0);
         end
      join
      abort_tile = 1'b0;
      repeat (4) @(negedge clk);
      check_output("post_rst_idle", out_valid, 0);
      r0 = rows_seen;
      l0 = lasts_seen;
      apply_stimulus(16'h6000, -1, 1'b1);
      wait_drain(40);
      check_output("fresh_rows", rows_seen - r0, 4);
      check_output("fresh_lasts", lasts_seen - l0, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
